// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Start loads operands; Done pulses once with {Cout,Sum} = A + B + Cin.
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Start,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] cat;

    assign s      = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    // New bit on top of the WIDTH-1 bits gathered so far
    assign cat    = {s, psum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= Cin;
                        psum  <= '0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= c_next;
                    psum  <= (WIDTH-1)'(cat >> 1);
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Sum   <= cat;
                        Cout  <= c_next;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder against an A+B+Cin model.
// Outputs are sampled on the falling edge; inputs change there too.
`timescale 1ns/1ps
module tb_serial_full_adder;

    localparam int W = 8;
    localparam logic [15:0] EXP_BUSY = 16'((1 << W) - 1);
    localparam logic [15:0] EXP_DONE = 16'(1 << W);

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Start;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Busy;
    logic         Done;

    int errors = 0;
    int checks = 0;

    serial_full_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Start (Start),
        .Sum   (Sum),
        .Cout  (Cout),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    endfunction

    // Drives one Start pulse and records Busy/Done per cycle after the accept edge.
    // glitch >= 0 raises Start with all-ones operands during that cycle index.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int glitch,
                         output logic [15:0] busy_pat, output logic [15:0] done_pat,
                         output logic [W:0] res, output logic [W:0] res_late,
                         output logic early);
        logic [W-1:0] s0;
        busy_pat = '0;
        done_pat = '0;
        res      = 'x;
        res_late = 'x;
        early    = 1'b0;
        s0       = '0;
        @(negedge clk);
        A = a; B = b; Cin = cin; Start = 1'b1;
        for (int i = 0; i <= W + 2; i++) begin
            @(negedge clk);
            if (i == 0) s0 = Sum;
            busy_pat[i] = Busy;
            done_pat[i] = Done;
            if (Done) res = {Cout, Sum};
            if (i < W && Sum !== s0) early = 1'b1;
            if (i == W + 2) res_late = {Cout, Sum};
            Start = (i == glitch);
            if (i == glitch) begin
                A = '1; B = '1; Cin = 1'b1;
            end else begin
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; A = '0; B = '0; Cin = 1'b0; Start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({Sum, Cout, Busy, Done} !== '0) begin
            errors++;
            $display("FAIL reset_async: got sum=%h cout=%b busy=%b done=%b want all 0",
                     Sum, Cout, Busy, Done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({Sum, Cout, Busy, Done} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got sum=%h cout=%b busy=%b done=%b want all 0",
                     Sum, Cout, Busy, Done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] bp, dp;
        logic [W:0] r, rl;
        logic e;
        do_op(8'h5A, 8'h3C, 1'b0, -1, bp, dp, r, rl, e);
        checks++;
        if (bp !== EXP_BUSY) begin
            errors++;
            $display("FAIL basic_busy: got %h want %h", bp, EXP_BUSY);
        end
        checks++;
        if (dp !== EXP_DONE) begin
            errors++;
            $display("FAIL basic_done: got %h want %h", dp, EXP_DONE);
        end
        checks++;
        if (r !== 9'h096) begin
            errors++;
            $display("FAIL basic_result: got %h want 096", r);
        end
        checks++;
        if (rl !== 9'h096 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got late=%h early_change=%b want 096 0", rl, e);
        end
    endtask

    task automatic test_ripple();
        logic [W-1:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
        logic         vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   ve [3] = '{9'h100, 9'h1FF, 9'h000};
        logic [15:0] bp, dp;
        logic [W:0] r, rl;
        logic e;
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], vc[k], -1, bp, dp, r, rl, e);
            checks++;
            if (r !== ve[k] || dp !== EXP_DONE || rl !== ve[k]) begin
                errors++;
                $display("FAIL ripple_%0d: got res=%h done=%h late=%h want %h %h %h",
                         k, r, dp, rl, ve[k], EXP_DONE, ve[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] bp, dp;
        logic [W:0] r, rl;
        logic e;
        do_op(8'h10, 8'h20, 1'b0, 2, bp, dp, r, rl, e);
        checks++;
        if (bp !== EXP_BUSY || dp !== EXP_DONE) begin
            errors++;
            $display("FAIL ignore_timing: got busy=%h done=%h want %h %h",
                     bp, dp, EXP_BUSY, EXP_DONE);
        end
        checks++;
        if (r !== 9'h030) begin
            errors++;
            $display("FAIL ignore_result: got %h want 030", r);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [15:0] bp, dp;
        logic [W:0] r, rl;
        logic e;
        @(negedge clk);
        A = 8'h77; B = 8'h11; Cin = 1'b0; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (Busy !== 1'b1 || Sum !== 8'h30) begin
            errors++;
            $display("FAIL midrst_pre: got busy=%b sum=%h want 1 30", Busy, Sum);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({Sum, Cout, Busy, Done} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got sum=%h cout=%b busy=%b done=%b want all 0",
                     Sum, Cout, Busy, Done);
        end
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (Done !== 1'b0 || Busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone: got activity=%b want 0", seen);
        end
        do_op(8'h01, 8'h01, 1'b1, -1, bp, dp, r, rl, e);
        checks++;
        if (r !== 9'h003 || dp !== EXP_DONE || bp !== EXP_BUSY) begin
            errors++;
            $display("FAIL midrst_after: got res=%h done=%h busy=%h want 003 %h %h",
                     r, dp, bp, EXP_DONE, EXP_BUSY);
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        logic [W:0] rq[$];
        logic [W-1:0] last;
        logic unstable;
        unstable = 1'b0;
        last = '0;
        @(negedge clk);
        A = 8'h80; B = 8'h80; Cin = 1'b0; Start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) begin
                dq.push_back(i);
                rq.push_back({Cout, Sum});
                last = Sum;
            end else if (dq.size() > 0 && Sum !== last) begin
                unstable = 1'b1;
            end
            if (i == 30) Start = 1'b0;
        end
        checks++;
        if (dq.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d dones want 4", dq.size());
        end
        for (int k = 0; k < dq.size(); k++) begin
            checks++;
            if (dq[k] != W + k * (W + 2) || rq[k] !== 9'h100) begin
                errors++;
                $display("FAIL b2b_pulse_%0d: got cycle=%0d res=%h want %0d 100",
                         k, dq[k], rq[k], W + k * (W + 2));
            end
        end
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stable: got unstable=%b want 0", unstable);
        end
    endtask

    task automatic test_random();
        logic [15:0] bp, dp;
        logic [W:0] r, rl, ex;
        logic [W-1:0] a, b;
        logic c, e;
        int g;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            g = (n % 3 == 0) ? int'($urandom_range(0, W)) : -1;
            ex = model(a, b, c);
            do_op(a, b, c, g, bp, dp, r, rl, e);
            checks++;
            if (r !== ex || rl !== ex || bp !== EXP_BUSY || dp !== EXP_DONE || e !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d: a=%h b=%h cin=%b got res=%h busy=%h done=%h want %h %h %h",
                         n, a, b, c, r, bp, dp, ex, EXP_BUSY, EXP_DONE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_full_adder.md
SERIAL_FULL_ADDER -- requirements
Module: serial_full_adder

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand and sum width in bits, with a legal range of 2..32.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port list (clock and reset first):
 - clk  input  1  single clock; all state changes on the rising edge.
 - rst_n  input  1  asynchronous, active-low reset.
 - A  input  WIDTH  addend, sampled only on an accepted Start.
 - B  input  WIDTH  addend, sampled only on an accepted Start.
 - Cin  input  1  carry-in, sampled only on an accepted Start.
 - Start  input  1  request to begin an addition.
 - Sum  output  WIDTH  result register.
 - Cout  output  1  carry-out register.
 - Busy  output  1  high while bits are being processed.
 - Done  output  1  one-cycle pulse marking a valid result.

Function
REQ-004 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 IDLE->SHIFT: on a rising edge with Start=1.
 - A and B load into internal shift registers.
 - The carry flop loads Cin.
 - The bit counter clears to 0.
REQ-006 SHIFT, on each rising edge:
 - A one-bit full adder operates on the shift-register LSBs and the carry flop.
 - s = a^b^c; c_next = (a&b)|(c&(a^b)).
 - s shifts into a partial-sum register from the MSB side.
 - Both operand registers shift right by one.
 - The carry flop takes c_next.
 - The counter increments.
REQ-007 SHIFT->DONE: on the edge that processes bit WIDTH-1, which is the WIDTH-th SHIFT edge.
 - On that same edge, Sum loads the complete partial sum and Cout loads the final carry.
REQ-008 DONE->IDLE: unconditionally on the next edge.
REQ-009 Busy SHALL be 1 exactly while in SHIFT; Done SHALL be 1 exactly while in DONE (one cycle).
REQ-010 Latency: with Start accepted at edge E0, Done SHALL be high during the cycle after edge E0+WIDTH and low after edge E0+WIDTH+1.
REQ-011 Start SHALL be ignored in SHIFT and DONE.
 - A, B and Cin changes outside an accepted Start have no effect.
 - The earliest next accept is the edge after DONE, i.e. in IDLE.
REQ-012 Sum and Cout SHALL hold their last result unchanged from the DONE cycle until the next completion; partial results are never visible on Sum.
REQ-013 Arithmetic SHALL be unsigned: {Cout,Sum} = A + B + Cin, exactly WIDTH+1 bits, with no truncation other than the Cout/Sum split.
REQ-014 Start held high continuously SHALL start a new addition on each IDLE edge, giving a period of WIDTH+2 cycles per result.
REQ-015 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within an operation.

Reset
REQ-016 rst_n=0 SHALL immediately, without waiting for clk, force:
 - state to IDLE;
 - Sum, Cout, Busy and Done to 0;
 - shift registers, carry flop and counter to 0.
REQ-017 A reset asserted mid-SHIFT SHALL abort the operation with no Done pulse; the previous Sum/Cout are lost (cleared to 0).
REQ-018 After rst_n deasserts, the first rising edge with Start=1 SHALL be accepted normally.

Verification
REQ-019 WIDTH=8, A=0x5A, B=0x3C, Cin=0, Start pulsed for one cycle:
 - Busy high for 8 cycles, then Done high for 1 cycle.
 - Sum=0x96, Cout=0.
REQ-020 Carry ripple, A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1.
 - Next, A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
 - Next, A=0x00, B=0x00, Cin=0 -> Sum=0x00, Cout=0.
REQ-021 Start ignored while busy: start A=0x10, B=0x20, Cin=0, then pulse Start with A=0xFF, B=0xFF at cycle 3 of SHIFT -> single Done, Sum=0x30, Cout=0, Busy timing unchanged.
REQ-022 Reset mid-operation: assert rst_n=0 asynchronously after 4 SHIFT cycles.
 - Outputs go to 0 before the next clk edge.
 - No Done pulse.
 - A subsequent A=0x01, B=0x01, Cin=1 -> Sum=0x03, Cout=0.
REQ-023 Start held high, A=0x80, B=0x80, Cin=0:
 - Done pulses every 10 cycles.
 - Each result is Sum=0x00, Cout=1.
 - Sum is stable between pulses.
REQ-024 Randomized WIDTH=8 sweep of at least 1000 operands plus Cin SHALL compare {Cout,Sum} against A+B+Cin at every Done.
